// File: rtl/mux_rr_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package mux_rr_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
interface mux_rr_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N-1:0]        i_valid;
    logic [N-1:0][W-1:0] i_data;
    logic [N-1:0]        i_last;
    logic [N-1:0]        o_ready;
    logic                o_valid;
    logic [W-1:0]        o_data;
    logic                o_last;
    logic [N-1:0]        o_sel;
    logic                i_ready;

    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_data, o_last, o_sel
    );

    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_sel
    );
endinterface

// File: rtl/mux.sv
// One-hot AND-OR multiplexer; an all-zero select yields an all-zero result.
module mux #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N-1:0]        i_sel,
    input  logic [N-1:0][W-1:0] i_data,
    output logic [W-1:0]        o_data
);

    always_comb begin
        // NOTE: default assigned first so every path drives o_data and no latch is inferred.
        o_data = '0;
        for (int j = 0; j < N; j++) begin
            o_data = o_data | (i_data[j] & {W{i_sel[j]}});
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// Round-robin grant generator with optional packet lock; pointer and lock state live here.
module mux_rr_arb
    import mux_rr_pkg::*;
#(
    parameter int N    = 4,
    parameter bit LOCK = 1'b1
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic [N-1:0] valid,
    input  logic [N-1:0] last,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    localparam int             PW       = ptr_w(N);
    localparam logic [PW-1:0]  LAST_IDX = PW'(N - 1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] rr_idx;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] lock_idx;
    logic [N-1:0]  rr_gnt;
    lock_state_e   state;
    logic          accept;
    logic          accept_last;

    // First valid channel at or after ptr, wrapping past N-1.
    always_comb begin : rr_search
        int   c;
        logic found;
        rr_gnt = '0;
        rr_idx = '0;
        found  = 1'b0;
        c      = 0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!found && valid[c]) begin
                found     = 1'b1;
                rr_gnt[c] = 1'b1;
                rr_idx    = PW'(c);
            end
        end
    end

    always_comb begin : grant_sel
        gnt     = rr_gnt;
        gnt_idx = rr_idx;
        if (state == LOCKED) begin
            gnt     = valid & (N'(1) << lock_idx);
            gnt_idx = lock_idx;
        end
    end

    assign accept      = adv & (|gnt);
    assign accept_last = |(gnt & last);
    assign ptr_nxt     = !accept                ? ptr :
                         (gnt_idx == LAST_IDX)  ? '0  :
                                                  gnt_idx + PW'(1);

    always_ff @(posedge clk or negedge arst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!arst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

    generate
        if (LOCK) begin : g_lock
            lock_state_e   state_nxt;
            logic [PW-1:0] lock_idx_nxt;

            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    state    <= UNLOCKED;
                    lock_idx <= '0;
                end else begin
                    state    <= state_nxt;
                    lock_idx <= lock_idx_nxt;
                end
            end

            // A multi-beat packet owns the output until its last beat is taken.
            always_comb begin
                state_nxt    = state;
                lock_idx_nxt = lock_idx;
                case (state)
                    UNLOCKED: begin
                        if (accept && !accept_last) begin
                            state_nxt    = LOCKED;
                            lock_idx_nxt = gnt_idx;
                        end
                    end
                    LOCKED: begin
                        if (accept && accept_last) begin
                            state_nxt = UNLOCKED;
                        end
                    end
                endcase
            end
        end else begin : g_free
            assign state    = UNLOCKED;
            assign lock_idx = '0;
        end
    endgenerate

endmodule

// File: rtl/mux_rr.sv
// Registered round-robin stream multiplexer: N valid/ready producers onto one
// output register stage, with optional whole-packet locking.
module mux_rr
    import mux_rr_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter bit LOCK = 1'b1
) (
    input logic     clk,
    input logic     arst_n,
    mux_rr_if.slave bus
);

    logic [N-1:0]        gnt;
    logic                adv;
    logic [N-1:0][W:0]   mux_in;
    logic [W:0]          mux_out;

    // The output register can take a beat when empty or when it drains this edge.
    assign adv         = !bus.o_valid | bus.i_ready;
    assign bus.o_ready = gnt & {N{adv}};

    mux_rr_arb #(
        .N    (N),
        .LOCK (LOCK)
    ) u_arb (
        .clk    (clk),
        .arst_n (arst_n),
        .valid  (bus.i_valid),
        .last   (bus.i_last),
        .adv    (adv),
        .gnt    (gnt)
    );

    for (genvar j = 0; j < N; j++) begin : g_pack
        assign mux_in[j] = {bus.i_last[j], bus.i_data[j]};
    end

    mux #(
        .N (N),
        .W (W + 1)
    ) u_mux (
        .i_sel  (gnt),
        .i_data (mux_in),
        .o_data (mux_out)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_last  <= 1'b0;
            bus.o_sel   <= '0;
        end else if (adv) begin
            bus.o_valid <= |gnt;
            bus.o_data  <= mux_out[W-1:0];
            bus.o_last  <= mux_out[W];
            bus.o_sel   <= gnt;
        end
    end

    a_ready_onehot: assert property (
        @(posedge clk) disable iff (!arst_n) $onehot0(bus.o_ready)
    );

    a_hold_on_stall: assert property (
        @(posedge clk) disable iff (!arst_n)
        (bus.o_valid && !bus.i_ready) |=>
            (bus.o_valid && $stable({bus.o_data, bus.o_last, bus.o_sel}))
    );

endmodule

// File: tb/tb_mux_rr.sv
// Directed bench for mux_rr: one free-running (LOCK=0) and one locking (LOCK=1) instance.
module tb_mux_rr;

    logic clk = 1'b0;
    logic arst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_rr_if #(.N(4), .W(8)) if0 ();
    mux_rr_if #(.N(4), .W(8)) if1 ();

    mux_rr #(.N(4), .W(8), .LOCK(1'b0)) dut0 (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (if0)
    );

    mux_rr #(.N(4), .W(8), .LOCK(1'b1)) dut1 (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (if1)
    );

    // Per-channel beat queues feeding the locking instance.
    logic [7:0] q_data [4][$];
    logic       q_last [4][$];
    logic [3:0] hold;

    task automatic idle_all();
        if0.i_valid = '0; if0.i_data = '0; if0.i_last = '0; if0.i_ready = 1'b1;
        if1.i_valid = '0; if1.i_data = '0; if1.i_last = '0; if1.i_ready = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            q_data[ch].delete();
            q_last[ch].delete();
        end
        hold = '0;
    endtask

    task automatic reset_on();
        arst_n = 1'b0;
        idle_all();
    endtask

    task automatic reset_off();
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic l);
        q_data[ch].push_back(d);
        q_last[ch].push_back(l);
    endtask

    task automatic apply1();
        for (int ch = 0; ch < 4; ch++) begin
            if (q_data[ch].size() > 0 && !hold[ch]) begin
                if1.i_valid[ch] = 1'b1;
                if1.i_data[ch]  = q_data[ch][0];
                if1.i_last[ch]  = q_last[ch][0];
            end else begin
                if1.i_valid[ch] = 1'b0;
                if1.i_data[ch]  = '0;
                if1.i_last[ch]  = 1'b0;
            end
        end
    endtask

    // One cycle on the locking instance: sample ready mid-cycle, pop accepted beats after the edge.
    task automatic tick1(output logic [3:0] rdy);
        @(negedge clk);
        rdy = if1.o_ready;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            if (rdy[ch]) begin
                void'(q_data[ch].pop_front());
                void'(q_last[ch].pop_front());
            end
        end
        apply1();
    endtask

    task automatic test_reset();
        logic [27:0] got;
        reset_on();
        if0.i_valid = 4'hF;
        if0.i_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        got = {if0.o_valid, if0.o_last, if0.o_sel, if0.o_data,
               if1.o_valid, if1.o_last, if1.o_sel, if1.o_data};
        total++;
        if (got !== 28'h0) begin
            bad++;
            $display("FAIL reset_async got=%h want=%h", got, 28'h0);
        end
        @(posedge clk);
        #1;
        got = {if0.o_valid, if0.o_last, if0.o_sel, if0.o_data,
               if1.o_valid, if1.o_last, if1.o_sel, if1.o_data};
        total++;
        if (got !== 28'h0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", got, 28'h0);
        end
        reset_off();
    endtask

    task automatic test_rotate();
        logic [13:0] got;
        logic [13:0] exp;
        logic [3:0]  s;
        logic [7:0]  d;
        reset_on();
        if0.i_valid = 4'hF;
        if0.i_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        reset_off();
        total++;
        if (if0.o_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rotate_first_ready got=%b want=%b", if0.o_ready, 4'b0001);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            s   = 4'b0001 << (i % 4);
            d   = 8'h10 + 8'(i % 4);
            exp = {1'b1, 1'b0, s, d};
            got = {if0.o_valid, if0.o_last, if0.o_sel, if0.o_data};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rotate_beat%0d got=%h want=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [13:0] got;
        reset_on();
        reset_off();
        if0.i_valid = 4'b0100;
        if0.i_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        if0.i_last  = 4'b0100;
        if0.i_ready = 1'b0;
        @(negedge clk);
        total++;
        if (if0.o_ready !== 4'b0100) begin
            bad++;
            $display("FAIL stall_load_ready got=%b want=%b", if0.o_ready, 4'b0100);
        end
        @(posedge clk);
        #1;
        if0.i_data[2] = 8'hB6;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = {if0.o_valid, if0.o_last, if0.o_sel, if0.o_data};
            total++;
            if (got !== {1'b1, 1'b1, 4'b0100, 8'hA5} || if0.o_ready !== 4'b0000) begin
                bad++;
                $display("FAIL stall_hold%0d got=%h ready=%b want=%h ready=0000",
                         k, got, if0.o_ready, {1'b1, 1'b1, 4'b0100, 8'hA5});
            end
        end
        if0.i_ready = 1'b1;
        #1;
        total++;
        if (if0.o_ready !== 4'b0100) begin
            bad++;
            $display("FAIL stall_release_ready got=%b want=%b", if0.o_ready, 4'b0100);
        end
        @(posedge clk);
        #1;
        if0.i_valid = '0;
        got = {if0.o_valid, if0.o_last, if0.o_sel, if0.o_data};
        total++;
        if (got !== {1'b1, 1'b1, 4'b0100, 8'hB6}) begin
            bad++;
            $display("FAIL stall_next_beat got=%h want=%h", got, {1'b1, 1'b1, 4'b0100, 8'hB6});
        end
        @(posedge clk);
        #1;
        got = {if0.o_valid, if0.o_last, if0.o_sel, if0.o_data};
        total++;
        if (got !== 14'h0) begin
            bad++;
            $display("FAIL stall_drain got=%h want=%h", got, 14'h0);
        end
    endtask

    task automatic test_lock_packet();
        logic [3:0]  rdy;
        logic [13:0] got;
        logic [3:0]  exp_rdy [5];
        logic [13:0] exp_out [5];
        exp_rdy = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
        exp_out = '{{2'b10, 4'b0010, 8'h41}, {2'b10, 4'b0010, 8'h42},
                    {2'b11, 4'b0010, 8'h43}, {2'b11, 4'b1000, 8'h63},
                    {2'b11, 4'b0001, 8'h30}};
        reset_on();
        push(0, 8'h20, 1'b1);
        apply1();
        reset_off();
        tick1(rdy);
        got = {if1.o_valid, if1.o_last, if1.o_sel, if1.o_data};
        total++;
        if (rdy !== 4'b0001 || got !== {2'b11, 4'b0001, 8'h20}) begin
            bad++;
            $display("FAIL lockpkt_prime got=%h ready=%b want=%h ready=0001",
                     got, rdy, {2'b11, 4'b0001, 8'h20});
        end
        push(0, 8'h30, 1'b1);
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        push(3, 8'h63, 1'b1);
        apply1();
        for (int i = 0; i < 5; i++) begin
            tick1(rdy);
            got = {if1.o_valid, if1.o_last, if1.o_sel, if1.o_data};
            total++;
            if (rdy !== exp_rdy[i]) begin
                bad++;
                $display("FAIL lockpkt_ready%0d got=%b want=%b", i, rdy, exp_rdy[i]);
            end
            total++;
            if (got !== exp_out[i]) begin
                bad++;
                $display("FAIL lockpkt_out%0d got=%h want=%h", i, got, exp_out[i]);
            end
        end
    endtask

    task automatic test_lock_bubble();
        logic [3:0]  rdy;
        logic [13:0] got;
        logic [3:0]  exp_rdy [6];
        logic [13:0] exp_out [6];
        exp_rdy = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
        exp_out = '{{2'b10, 4'b0001, 8'h50}, 14'h0, 14'h0,
                    {2'b10, 4'b0001, 8'h51}, {2'b11, 4'b0001, 8'h52},
                    {2'b11, 4'b0010, 8'h71}};
        reset_on();
        push(0, 8'h50, 1'b0);
        push(0, 8'h51, 1'b0);
        push(0, 8'h52, 1'b1);
        push(1, 8'h71, 1'b1);
        apply1();
        reset_off();
        for (int i = 0; i < 6; i++) begin
            tick1(rdy);
            got = {if1.o_valid, if1.o_last, if1.o_sel, if1.o_data};
            total++;
            if (rdy !== exp_rdy[i] || got !== exp_out[i]) begin
                bad++;
                $display("FAIL bubble_step%0d got=%h ready=%b want=%h ready=%b",
                         i, got, rdy, exp_out[i], exp_rdy[i]);
            end
            hold[0] = (i == 0 || i == 1);
            apply1();
        end
    endtask

    task automatic lock_ch0_then_reset();
        logic [3:0]  rdy;
        logic [13:0] got;
        reset_on();
        push(0, 8'h90, 1'b0);
        push(0, 8'h91, 1'b0);
        push(0, 8'h92, 1'b1);
        apply1();
        reset_off();
        tick1(rdy);
        got = {if1.o_valid, if1.o_last, if1.o_sel, if1.o_data};
        total++;
        if (got !== {2'b10, 4'b0001, 8'h90}) begin
            bad++;
            $display("FAIL midrst_lock got=%h want=%h", got, {2'b10, 4'b0001, 8'h90});
        end
        reset_on();
        #1;
        got = {if1.o_valid, if1.o_last, if1.o_sel, if1.o_data};
        total++;
        if (got !== 14'h0) begin
            bad++;
            $display("FAIL midrst_clear got=%h want=%h", got, 14'h0);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [3:0]  rdy;
        logic [13:0] got;
        lock_ch0_then_reset();
        push(3, 8'hE3, 1'b1);
        apply1();
        reset_off();
        tick1(rdy);
        got = {if1.o_valid, if1.o_last, if1.o_sel, if1.o_data};
        total++;
        if (rdy !== 4'b1000 || got !== {2'b11, 4'b1000, 8'hE3}) begin
            bad++;
            $display("FAIL midrst_unlock got=%h ready=%b want=%h ready=1000",
                     got, rdy, {2'b11, 4'b1000, 8'hE3});
        end
        lock_ch0_then_reset();
        push(0, 8'hC0, 1'b1);
        push(3, 8'hE3, 1'b1);
        apply1();
        reset_off();
        tick1(rdy);
        got = {if1.o_valid, if1.o_last, if1.o_sel, if1.o_data};
        total++;
        if (rdy !== 4'b0001 || got !== {2'b11, 4'b0001, 8'hC0}) begin
            bad++;
            $display("FAIL midrst_ptr got=%h ready=%b want=%h ready=0001",
                     got, rdy, {2'b11, 4'b0001, 8'hC0});
        end
    endtask

    initial begin
        arst_n = 1'b0;
        idle_all();
        test_reset();
        test_rotate();
        test_stall();
        test_lock_packet();
        test_lock_bubble();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog run did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mux_rr.md
# mux_rr

Registered, round-robin arbitrating stream multiplexer. It selects one of N valid/ready input channels per beat and forwards that channel's data and last flag through a single output register stage. Optional packet locking holds the grant until the owning channel's last beat. It sits wherever several producers share one downstream consumer, and uses the existing one-hot `mux` for the datapath select.

## Interface
- N, 4, number of input channels; N >= 2
- W, 32, data width per channel; W >= 1
- LOCK, 1, 1: grant held from first beat until the beat with last; 0: re-arbitrate every beat
- clk  in  1  clock; all state updates on rising edge
- arst_n  in  1  asynchronous reset, active-low
- i_valid  in  N  per-channel beat valid
- i_data  in  N x W  per-channel beat data, packed [N-1:0][W-1:0]
- i_last  in  N  per-channel end-of-packet flag
- o_ready  out  N  per-channel accept; at most one bit set
- o_valid  out  1  output beat valid (registered)
- o_data  out  W  output beat data (registered)
- o_last  out  1  output beat last (registered)
- o_sel  out  N  one-hot source channel of the current output beat (registered)
- i_ready  in  1  downstream accept

Reset: asynchronous and active-low on arst_n, one clock clk.

## Operation
- Handshake: a beat transfers on any edge where valid & ready. Producers hold valid/data/last stable until accepted. o_valid is not dropped before i_ready.
- Output register: adv = !o_valid | i_ready. When adv, the register loads the granted beat. If no channel is granted, o_valid goes 0.
- Grant: one-hot gnt[N-1:0], combinational from i_valid, the priority pointer and the lock state. o_ready = gnt & {N{adv}}.
- Round-robin: the pointer p (index, $clog2(N) bits) marks the highest-priority channel. Search order is p, p+1, ..., N-1, 0, ..., p-1 (wrap-around). After each accepted beat from channel k, p becomes (k+1) mod N. With no transfer, p is unchanged.
- Lock FSM (LOCK=1):
  - UNLOCKED: arbitrate normally.
  - UNLOCKED -> LOCKED(k): a beat is accepted from k with i_last[k]=0.
  - LOCKED(k): gnt = onehot(k) & i_valid[k]. All other channels are starved. If i_valid[k] drops, nothing is granted; the lock is held and the output may bubble.
  - LOCKED(k) -> UNLOCKED: a beat from k with i_last[k]=1 is accepted. The pointer then moves to k+1.
  - Single-beat packet (first beat has last=1): stays UNLOCKED.
- LOCK=0: the FSM is absent. The pointer rotates per beat and i_last is forwarded only.
- The data, last and o_sel select uses `mux` with i_sel = gnt. This gives a zero result when gnt is 0.
- Reset values: o_valid=0, o_data=0, o_last=0, o_sel=0, p=0, state UNLOCKED.
- Reset mid-packet: the lock clears, and any in-flight output beat is discarded. Packet integrity is the upstream's responsibility.

## Timing
- Latency: 1 cycle from input acceptance to o_valid.
- Throughput: 1 beat/cycle while i_ready=1 and a grantable channel is valid.
- Combinational paths: i_ready -> o_ready, and i_valid -> o_ready. There is no combinational path from input to o_valid, o_data or o_last.
- Simultaneous events: when the output beat drains and a new beat loads on the same edge, o_valid stays 1. A lock release and a new grant to a different channel cannot occur in the same cycle, because the grant of the release cycle is k.

## Structure
- Sub-module `mux_rr_arb`: pointer, lock FSM and grant generation; outputs gnt.
- Datapath: instantiate `mux` (N, W+1) over {i_last, i_data}. o_sel is registered from gnt.
- Shared package: the lock state enum (UNLOCKED, LOCKED) and the pointer width function go in the common package. No other constants are needed.

## Test plan
- N=4, W=8, LOCK=0, all four channels continuously valid (ch j data = 8'h10+j), i_ready=1 -> o_data sequence 10,11,12,13,10,..., one per cycle, starting 1 cycle after release of reset.
- Only ch2 valid, data A5, last=1, i_ready=0 for 3 cycles -> o_valid=1, o_data=A5, o_sel=4'b0100 held stable for 3 cycles; o_ready all 0 during the stall; transfer when i_ready=1.
- LOCK=1: ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch3 are valid throughout -> three consecutive ch1 beats, then ch3, then ch0 (pointer at 2 after release).
- LOCK=1: ch0 locked, then i_valid[0] drops for 2 cycles while ch1 is valid -> o_ready[1] stays 0 and the output bubbles; ch0 resumes and finishes the packet, then ch1 is granted.
- arst_n asserted mid-packet with o_valid=1 -> all outputs 0 immediately. After release, ch3 alone valid is granted on the first cycle (lock cleared, p=0).
